// File: rtl/lc3_ctrl_pkg.sv
// Shared LC-3 control definitions: fetch state encoding, PC mux selects, opcodes
// and the per-state strobe decode used by the fetch sequencer.
package lc3_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        FETCH3 = 3'd3,
        DECODE = 3'd4,
        FAULT  = 3'd5
    } fetch_state_t;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef struct packed {
        logic       gate_pc;
        logic       ld_mar;
        logic       ld_pc;
        logic [1:0] pcmux_sel;
        logic       mio_en;
        logic       ld_mdr;
        logic       gate_mdr;
        logic       ld_ir;
        logic       ir_valid;
        logic       busy;
        logic       fault;
    } strobe_t;

    // Moore decode: strobes depend only on the state they are registered for.
    function automatic strobe_t fetch_strobes(fetch_state_t s);
        strobe_t o;
        o = '0;
        case (s)
            FETCH1: begin
                o.gate_pc   = 1'b1;
                o.ld_mar    = 1'b1;
                o.ld_pc     = 1'b1;
                o.pcmux_sel = PCMUX_INC;
                o.busy      = 1'b1;
            end
            FETCH2: begin
                o.mio_en = 1'b1;
                o.ld_mdr = 1'b1;
                o.busy   = 1'b1;
            end
            FETCH3: begin
                o.gate_mdr = 1'b1;
                o.ld_ir    = 1'b1;
                o.busy     = 1'b1;
            end
            DECODE: begin
                o.ir_valid = 1'b1;
                o.busy     = 1'b1;
            end
            FAULT: begin
                o.busy  = 1'b1;
                o.fault = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lc3_fetch_ctrl_if.sv
// Control/strobe bundle between the fetch sequencer (master) and the
// control unit plus PC/MAR/MDR/IR datapath registers (slave).
interface lc3_fetch_ctrl_if #(parameter int CNT_W = 16);
    logic             start;
    logic             halt;
    logic             mem_ready;
    logic             exec_done;
    logic             gate_pc;
    logic             ld_mar;
    logic             ld_pc;
    logic [1:0]       pcmux_sel;
    logic             mio_en;
    logic             ld_mdr;
    logic             gate_mdr;
    logic             ld_ir;
    logic             ir_valid;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  start, halt, mem_ready, exec_done,
        output gate_pc, ld_mar, ld_pc, pcmux_sel, mio_en, ld_mdr, gate_mdr,
               ld_ir, ir_valid, busy, fault, fetch_count
    );

    modport slave (
        output start, halt, mem_ready, exec_done,
        input  gate_pc, ld_mar, ld_pc, pcmux_sel, mio_en, ld_mdr, gate_mdr,
               ld_ir, ir_valid, busy, fault, fetch_count
    );
endinterface

// File: rtl/lc3_fetch_wdog.sv
// Memory-wait watchdog: counts consecutive FETCH2 cycles without mem_ready.
// Latency: tmo is combinational in the TMO_CYC-th waiting cycle; no backpressure.
// Counter clears whenever the sequencer is outside FETCH2.
module lc3_fetch_wdog #(
    parameter int TMO_CYC = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic in_fetch2,
    input  logic mem_ready,
    output logic tmo
);
    localparam int         W    = $clog2(TMO_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TMO_CYC - 1);

    logic [W-1:0] wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (!in_fetch2) begin
            wait_q <= '0;
        end else if (!mem_ready) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    // A late mem_ready in the final cycle still wins over the timeout.
    assign tmo = in_fetch2 && !mem_ready && (wait_q == LAST);
endmodule

// File: rtl/lc3_fetch_ctrl.sv
// LC-3 instruction-fetch sequencer: PC->MAR, MEM->MDR, MDR->IR, then hold for execute.
// Latency: start to ld_ir is 3 edges minimum; FETCH2 stalls on mem_ready, DECODE on exec_done.
// LC3_FETCH_TIMEOUT_EN adds a FETCH2 watchdog that parks the FSM in a sticky FAULT state.
module lc3_fetch_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
`ifdef LC3_FETCH_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 32
`endif
) (
    input logic               clk,
    input logic               rst,
    lc3_fetch_ctrl_if.master  bus
);
    fetch_state_t     state;
    fetch_state_t     nxt;
    strobe_t          out_q;
    logic [CNT_W-1:0] cnt_q;

`ifdef LC3_FETCH_TIMEOUT_EN
    logic tmo;

    lc3_fetch_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .in_fetch2 (state == FETCH2),
        .mem_ready (bus.mem_ready),
        .tmo       (tmo)
    );
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (bus.start && !bus.halt) nxt = FETCH1;
            FETCH1: nxt = FETCH2;
            FETCH2: begin
                if (bus.mem_ready) nxt = FETCH3;
`ifdef LC3_FETCH_TIMEOUT_EN
                else if (tmo) nxt = FAULT;
`endif
            end
            FETCH3: nxt = DECODE;
            DECODE: if (bus.exec_done) nxt = bus.halt ? IDLE : FETCH1;
            FAULT:  nxt = FAULT;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= nxt;
            out_q <= fetch_strobes(nxt);
`ifndef LC3_FETCH_TIMEOUT_EN
            out_q.fault <= 1'b0;
`endif
            if (state == FETCH3) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.gate_pc     = out_q.gate_pc;
    assign bus.ld_mar      = out_q.ld_mar;
    assign bus.ld_pc       = out_q.ld_pc;
    assign bus.pcmux_sel   = out_q.pcmux_sel;
    assign bus.mio_en      = out_q.mio_en;
    assign bus.ld_mdr      = out_q.ld_mdr;
    assign bus.gate_mdr    = out_q.gate_mdr;
    assign bus.ld_ir       = out_q.ld_ir;
    assign bus.ir_valid    = out_q.ir_valid;
    assign bus.busy        = out_q.busy;
    assign bus.fault       = out_q.fault;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Self-checking bench for lc3_fetch_ctrl: per-transaction expected strobe traces,
// two instances (16-bit and 4-bit fetch counters) driven in lock-step.
module tb_lc3_fetch_ctrl;
    localparam int TMO = 32;

    // {gate_pc, ld_mar, ld_pc, pcmux[1:0], mio_en, ld_mdr, gate_mdr, ld_ir, ir_valid, busy, fault}
    localparam logic [11:0] O_IDLE  = 12'b0000_0000_0000;
    localparam logic [11:0] O_F1    = 12'b1110_0000_0010;
    localparam logic [11:0] O_F2    = 12'b0000_0110_0010;
    localparam logic [11:0] O_F3    = 12'b0000_0001_1010;
    localparam logic [11:0] O_DEC   = 12'b0000_0000_0110;
    localparam logic [11:0] O_FAULT = 12'b0000_0000_0011;

    typedef struct {
        logic [11:0] o;
        logic [15:0] c;
        logic        st;
        logic        hl;
        logic        mr;
        logic        ed;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, halt = 1'b0, mem_ready = 1'b0, exec_done = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] m_cnt = '0;
    step_t tq[$];

    always #5 clk = ~clk;

    lc3_fetch_ctrl_if #(.CNT_W(16)) ifa ();
    lc3_fetch_ctrl_if #(.CNT_W(4))  ifb ();

    assign ifa.start = start;     assign ifb.start = start;
    assign ifa.halt = halt;       assign ifb.halt = halt;
    assign ifa.mem_ready = mem_ready; assign ifb.mem_ready = mem_ready;
    assign ifa.exec_done = exec_done; assign ifb.exec_done = exec_done;

    lc3_fetch_ctrl #(
        .CNT_W(16)
`ifdef LC3_FETCH_TIMEOUT_EN
        , .TMO_CYC(TMO)
`endif
    ) dut (.clk(clk), .rst(rst), .bus(ifa));

    lc3_fetch_ctrl #(
        .CNT_W(4)
`ifdef LC3_FETCH_TIMEOUT_EN
        , .TMO_CYC(TMO)
`endif
    ) dut4 (.clk(clk), .rst(rst), .bus(ifb));

    logic [11:0] obs_a, obs_b;
    assign obs_a = {ifa.gate_pc, ifa.ld_mar, ifa.ld_pc, ifa.pcmux_sel, ifa.mio_en, ifa.ld_mdr,
                    ifa.gate_mdr, ifa.ld_ir, ifa.ir_valid, ifa.busy, ifa.fault};
    assign obs_b = {ifb.gate_pc, ifb.ld_mar, ifb.ld_pc, ifb.pcmux_sel, ifb.mio_en, ifb.ld_mdr,
                    ifb.gate_mdr, ifb.ld_ir, ifb.ir_valid, ifb.busy, ifb.fault};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- reference model: expected per-cycle trace ----------------
    task automatic push(input logic [11:0] o, input logic st, input logic hl,
                        input logic mr, input logic ed);
        step_t s;
        s.o = o; s.c = m_cnt; s.st = st; s.hl = hl; s.mr = mr; s.ed = ed;
        tq.push_back(s);
    endtask

    // Idle cycles never present start&!halt; a trailing 'go' cycle does.
    task automatic add_idle(input int n, input bit go);
        for (int i = 0; i < n; i++) begin
            logic st;
            st = rb();
            push(O_IDLE, st, st ? 1'b1 : rb(), rb(), rb());
        end
        if (go) push(O_IDLE, 1'b1, 1'b0, rb(), rb());
    endtask

    // One instruction: mem_ready after d wait cycles, exec_done after e decode cycles.
    task automatic add_fetch(input int d, input int e, input bit h);
        push(O_F1, rb(), rb(), rb(), rb());
        for (int j = 0; j <= d; j++) push(O_F2, rb(), rb(), (j == d), rb());
        push(O_F3, rb(), rb(), rb(), rb());
        m_cnt = m_cnt + 16'd1;
        for (int j = 0; j <= e; j++)
            push(O_DEC, rb(), (j == e) ? h : rb(), rb(), (j == e));
    endtask

    task automatic run_trace(input string name);
        int cyc;
        step_t s;
        cyc = 0;
        while (tq.size() > 0) begin
            s = tq.pop_front();
            @(negedge clk);
            n_chk++;
            if (obs_a !== s.o || ifa.fetch_count !== s.c) begin
                n_fail++;
                $display("FAIL %s cyc %0d: strobes=%b count=%0d, expected strobes=%b count=%0d",
                         name, cyc, obs_a, ifa.fetch_count, s.o, s.c);
            end
            n_chk++;
            if (obs_b !== s.o || ifb.fetch_count !== s.c[3:0]) begin
                n_fail++;
                $display("FAIL %s_w4 cyc %0d: strobes=%b count=%0d, expected strobes=%b count=%0d",
                         name, cyc, obs_b, ifb.fetch_count, s.o, s.c[3:0]);
            end
            start = s.st; halt = s.hl; mem_ready = s.mr; exec_done = s.ed;
            cyc++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0; halt = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
        #1;
        m_cnt = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs_a !== 12'd0 || ifa.fetch_count !== 16'd0 || ifb.fetch_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: strobes=%b count=%0d, expected all zero", obs_a, ifa.fetch_count);
        end
        rst = 1'b0;
        add_idle(2, 1);
        add_fetch(1, 2, 0);
        push(O_F1, rb(), rb(), rb(), rb());
        for (int j = 0; j < 3; j++) push(O_F2, rb(), rb(), 1'b0, rb());
        run_trace("pre_reset");
        pulse_reset();
        n_chk++;
        if (obs_a !== 12'd0 || ifa.fetch_count !== 16'd0 || ifb.fetch_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_fetch2: strobes=%b count=%0d, expected all zero", obs_a, ifa.fetch_count);
        end
        #1 rst = 1'b0;
        add_idle(1, 1);
        add_fetch(0, 0, 1);
        add_idle(1, 0);
        run_trace("restart");
    endtask

    task automatic test_single_fetch();
        add_idle(1, 1);
        add_fetch(0, 1, 1);
        add_idle(1, 0);
        run_trace("single_fetch");
    endtask

    task automatic test_mem_wait();
        add_idle(1, 1);
        add_fetch(5, 0, 1);
        add_idle(2, 0);
        run_trace("mem_wait");
    endtask

    task automatic test_back_to_back();
        add_idle(1, 1);
        for (int i = 0; i < 10; i++)
            add_fetch($urandom_range(0, 4), $urandom_range(0, 3), 0);
        add_fetch($urandom_range(0, 4), $urandom_range(0, 3), 1);
        add_idle(2, 0);
        run_trace("back_to_back");
        n_chk++;
        if (ifa.busy !== 1'b0 || ifa.fetch_count !== m_cnt) begin
            n_fail++;
            $display("FAIL halt_idle: busy=%b count=%0d, expected busy=0 count=%0d",
                     ifa.busy, ifa.fetch_count, m_cnt);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            add_idle($urandom_range(0, 3), 1);
            while (1) begin
                bit h;
                h = ($urandom_range(0, 3) == 0);
                add_fetch($urandom_range(0, 6), $urandom_range(0, 4), h);
                if (h) break;
            end
        end
        add_idle(1, 0);
        run_trace("random");
    endtask

    task automatic test_wrap();
        pulse_reset();
        #1 rst = 1'b0;
        add_idle(1, 1);
        for (int i = 0; i < 16; i++) add_fetch(0, 0, 0);
        add_fetch(0, 0, 1);
        add_idle(1, 0);
        run_trace("wrap");
        n_chk++;
        if (ifb.fetch_count !== 4'd1 || ifa.fetch_count !== 16'd17) begin
            n_fail++;
            $display("FAIL count_wrap: w4=%0d w16=%0d, expected w4=1 w16=17",
                     ifb.fetch_count, ifa.fetch_count);
        end
    endtask

`ifdef LC3_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        pulse_reset();
        #1 rst = 1'b0;
        add_idle(1, 1);
        push(O_F1, rb(), rb(), rb(), rb());
        for (int j = 0; j < TMO; j++) push(O_F2, rb(), rb(), 1'b0, rb());
        for (int k = 0; k < 6; k++) push(O_FAULT, rb(), rb(), rb(), rb());
        run_trace("timeout");
        @(negedge clk);
        n_chk++;
        if (ifa.fault !== 1'b1 || ifa.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky: fault=%b busy=%b, expected 1 1", ifa.fault, ifa.busy);
        end
        pulse_reset();
        n_chk++;
        if (ifa.fault !== 1'b0 || ifa.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%b busy=%b, expected 0 0", ifa.fault, ifa.busy);
        end
        #1 rst = 1'b0;
        add_idle(1, 1);
        add_fetch(TMO - 1, 0, 1);
        add_idle(1, 0);
        run_trace("ready_last_cycle");
    endtask
`else
    task automatic test_no_timeout();
        add_idle(1, 1);
        add_fetch(TMO + 8, 1, 1);
        add_idle(2, 0);
        run_trace("long_wait");
        n_chk++;
        if (ifa.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL no_fault: fault=%b, expected 0", ifa.fault);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_mem_wait();
        test_back_to_back();
        test_random();
        test_wrap();
`ifdef LC3_FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
